// File: rtl/uart_receiver.sv
// UART receive engine: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Optional macro UART_RX_HOLD_EN turns rx_valid into a level with rx_ack/overrun handshake.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned CNT_W        = 14
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       enable,
  input  logic       frame_type,  // 1 = frame carries an even-parity bit
`ifdef UART_RX_HOLD_EN
  input  logic       rx_ack,
  output logic       overrun,
`endif
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       status,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, rs_q, rs_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             ptype_q, ptype_d;
  logic             perr_q, perr_d;
  logic             line_hold_q, line_hold_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             done;
`ifdef UART_RX_HOLD_EN
  logic             overrun_q, overrun_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    ptype_d      = ptype_q;
    perr_d       = perr_q;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && rs_prev_q && !rs_q && !line_hold_q) begin
          state_d = S_START;
          cnt_d   = '0;
          ptype_d = frame_type;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          if (rs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[bit_idx_q] = rs_q;
          cnt_d              = '0;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ptype_q ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          perr_d  = rs_q ^ (^shift_q);
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs register at the stop-sample edge so they appear the cycle after sampling.
  always_comb begin
    rx_data_d    = rx_data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    line_hold_d  = line_hold_q;
    if (done) begin
      rx_data_d    = shift_q;
      frame_err_d  = ~rs_q;
      parity_err_d = perr_q & ptype_q;
    end
    if (done && !rs_q) begin
      line_hold_d = 1'b1;
    end else if (rs_q) begin
      line_hold_d = 1'b0;
    end
`ifdef UART_RX_HOLD_EN
    rx_valid_d = done | (rx_valid_q & ~rx_ack);
    overrun_d  = overrun_q;
    if (done && rx_valid_q && !rx_ack) begin
      overrun_d = 1'b1;
    end else if (rx_ack) begin
      overrun_d = 1'b0;
    end
`else
    rx_valid_d = done;
`endif
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      rs_q         <= 1'b1;
      rs_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      ptype_q      <= 1'b0;
      perr_q       <= 1'b0;
      line_hold_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_HOLD_EN
      overrun_q    <= 1'b0;
`endif
    end else begin
      sync1_q      <= rxd;
      rs_q         <= sync1_q;
      rs_prev_q    <= rs_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      ptype_q      <= ptype_d;
      perr_q       <= perr_d;
      line_hold_q  <= line_hold_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_HOLD_EN
      overrun_q    <= overrun_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign status     = (state_q != S_IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
`ifdef UART_RX_HOLD_EN
  assign overrun    = overrun_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: vector table plus corner sequences.
module tb_uart_receiver;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rxd    = 1'b1;
  logic       enable = 1'b1;
  logic       frame_type = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       status;
  logic       frame_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] q_data[$];
  logic       q_fe[$];
  logic       q_pe[$];
  int         q_cyc[$];
  logic       prev_valid = 1'b0;
  int         last_cyc;

  uart_receiver #(
    .CLKS_PER_BIT(16),
    .CNT_W       (5)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .enable    (enable),
    .frame_type(frame_type),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .status    (status),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge sysclk) begin
    if (rx_valid) begin
      chk("rx_valid_width", {31'd0, prev_valid}, 32'd0);
      q_data.push_back(rx_data);
      q_fe.push_back(frame_err);
      q_pe.push_back(parity_err);
      q_cyc.push_back(cyc);
    end
    prev_valid = rx_valid;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit par,
                            input bit stop, input bit drop_en, input int post_low,
                            output int start_cyc);
    frame_type = has_par;
    rxd        = 1'b0;
    start_cyc  = cyc;
    repeat (16) tick();
    frame_type = ~has_par;
    for (int unsigned i = 0; i < 8; i++) begin
      rxd = d[i];
      if (i == 3) begin
        if (drop_en) enable = 1'b0;
        repeat (8) tick();
        chk("status_mid", {31'd0, status}, 32'd1);
        repeat (8) tick();
      end else begin
        repeat (16) tick();
      end
    end
    if (has_par) begin
      rxd = par;
      repeat (16) tick();
    end
    rxd = stop;
    repeat (16) tick();
    if (post_low > 0) begin
      repeat (post_low) tick();
      chk("status_low_hold", {31'd0, status}, 32'd0);
      chk("no_start_low_hold", {31'd0, dut.state_q != 3'd0}, 32'd0);
    end
    rxd    = 1'b1;
    enable = 1'b1;
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d, input bit fe, input bit pe);
    int n = 0;
    while (q_data.size() == 0 && n < 64) begin
      tick();
      n++;
    end
    if (q_data.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_rx_valid expected=rx_valid", name);
    end else begin
      chk({name, "_data"}, {24'd0, q_data.pop_front()}, {24'd0, d});
      chk({name, "_frame_err"}, {31'd0, q_fe.pop_front()}, {31'd0, fe});
      chk({name, "_parity_err"}, {31'd0, q_pe.pop_front()}, {31'd0, pe});
      last_cyc = q_cyc.pop_front();
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ptype;
    bit         par;
    bit         stop;
    bit         drop_en;
    logic [7:0] exp_data;
    bit         exp_fe;
    bit         exp_pe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int sc, sc2, first_cyc;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};
    vecs[7] = '{8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96, 1'b1, 1'b1};

    repeat (3) tick();
    chk("rst_rx_data", {24'd0, rx_data}, 32'h0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_status", {31'd0, status}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    for (int unsigned i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].ptype, vecs[i].par, vecs[i].stop, vecs[i].drop_en, 0, sc);
      expect_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe);
      chk_range($sformatf("vec%0d_latency", i), last_cyc - sc,
                154 + 16 * int'(vecs[i].ptype), 156 + 16 * int'(vecs[i].ptype));
      repeat (20) tick();
      chk($sformatf("vec%0d_hold_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
      chk($sformatf("vec%0d_status_idle", i), {31'd0, status}, 32'd0);
    end

    // Short low glitch on an idle line must be rejected at the mid-start sample.
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (3) tick();
    chk("glitch_status_seen", {31'd0, status}, 32'd1);
    repeat (30) tick();
    chk("glitch_status_back", {31'd0, status}, 32'd0);
    chk("glitch_no_strobe", q_data.size(), 0);

    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 40, sc);
    expect_frame("ferr55", 8'h55, 1'b1, 1'b0);
    repeat (20) tick();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 0, sc);
    expect_frame("after_ferr0F", 8'h0F, 1'b0, 1'b0);
    repeat (20) tick();

    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 0, sc);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 0, sc2);
    expect_frame("b2b_01", 8'h01, 1'b0, 1'b0);
    first_cyc = last_cyc;
    expect_frame("b2b_FE", 8'hFE, 1'b0, 1'b0);
    chk_range("b2b_spacing", last_cyc - first_cyc, 159, 161);
    repeat (20) tick();

    // Abort a frame with reset during data bit 4.
    rxd = 1'b0;
    repeat (16) tick();
    rxd = 1'b1;
    repeat (16) tick();
    rxd = 1'b0;
    repeat (48) tick();
    rxd = 1'b1;
    repeat (8) tick();
    chk("pre_abort_status", {31'd0, status}, 32'd1);
    rst_n = 1'b0;
    repeat (3) tick();
    chk("abort_status", {31'd0, status}, 32'd0);
    chk("abort_rx_data", {24'd0, rx_data}, 32'h0);
    rst_n = 1'b1;
    repeat (200) tick();
    chk("abort_no_strobe", q_data.size(), 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 0, sc);
    expect_frame("after_abort81", 8'h81, 1'b0, 1'b0);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial UART receive engine: recovers 8-bit frames from the idle-high rxd line.
- Frame: start bit, 8 data bits LSB first, optional even-parity bit, one stop bit.
- Bit timing matches the baud generator / transmit path (CLKS_PER_BIT sysclk cycles per bit).
- Delivers each byte to the peripheral bus interface with a valid strobe and error flags.

Parameters:
- CLKS_PER_BIT, 10416, sysclk cycles per bit (100 MHz / 9600 baud); must be >= 4.
- CNT_W, 14, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- sysclk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rxd  input  1  asynchronous serial line, idle high
- enable  input  1  1 = start-bit detection armed
- type  input  1  1 = frame carries a 9th (even parity) bit; latched at start detect
- rx_data  output  8  received byte, valid while rx_valid=1
- rx_valid  output  1  one-cycle strobe per completed frame
- status  output  1  1 while a frame is in progress (any state other than IDLE)
- frame_err  output  1  stop bit sampled low; qualified by rx_valid
- parity_err  output  1  parity mismatch; qualified by rx_valid; 0 when type latched 0

Behaviour:
- Reset:
  - rx_data=0, rx_valid=0, status=0, frame_err=0, parity_err=0.
  - State IDLE; synchronizer flops reset to 1.
  - Reset asserted mid-frame aborts the frame; no strobe is emitted.
- rxd passes through a 2-flop synchronizer; all decisions use the synchronized value rs.
- IDLE:
  - If enable=1 and rs falls (previous 1, current 0): go to START, counter=0, latch type into ptype.
  - If line_hold=1, rs must be seen high for at least one cycle before a falling edge is accepted.
- START:
  - Counter increments each cycle. At counter = CLKS_PER_BIT/2 - 1 (integer division), sample rs.
  - rs=1 is a false start: return to IDLE, no strobe.
  - rs=0: counter=0, bit index=0, go to DATA.
- DATA:
  - At counter = CLKS_PER_BIT-1, sample rs into shift[bit index] (LSB first), counter=0, bit index+1.
  - After the 8th sample: go to PARITY if ptype=1, else STOP.
- PARITY: at counter = CLKS_PER_BIT-1, sample rs; perr = rs XOR (XOR of the 8 data bits), i.e. even parity. Go to STOP.
- STOP:
  - At counter = CLKS_PER_BIT-1, sample rs.
  - Next cycle: rx_data=shift, rx_valid=1, frame_err = ~sample, parity_err = perr & ptype. Return to IDLE.
  - Sampling happens at mid-stop, so the receiver re-arms half a bit early for back-to-back frames.
  - frame_err=1 sets line_hold, which clears when rs=1.
- Output hold:
  - rx_data, frame_err and parity_err hold their values until the next strobe.
  - rx_valid is exactly one cycle wide.
- enable only gates start detection. Deasserting it mid-frame does not abort the frame.
- type changes mid-frame are ignored; ptype is used for the whole frame.
- Counter width is CNT_W and never wraps: it is cleared at every sample point.
- Latency: rx_valid rises 2 (sync) + CLKS_PER_BIT/2 + (9 + ptype)·CLKS_PER_BIT + 1 cycles after the rxd falling edge, ±1 cycle for synchronizer phase.

Optional Feature:
- Macro: UART_RX_HOLD_EN.
- Defined:
  - Adds ports rx_ack (input, 1) and overrun (output, 1, reset 0).
  - rx_valid becomes a level: set at frame completion, cleared on the cycle after rx_ack=1 is sampled.
  - rx_data and the error flags are held while rx_valid=1.
  - If a frame completes while rx_valid=1 and rx_ack=0: the new byte overwrites rx_data and overrun is set (sticky until the next rx_ack).
  - Completion and rx_ack in the same cycle: the new byte is loaded, rx_valid stays 1, no overrun.
- Not defined: ports absent; rx_valid is a one-cycle strobe as above.

Test Plan:
- CLKS_PER_BIT=16, type=0: send 0xA5 with stop bit high -> one rx_valid pulse, rx_data=0xA5, frame_err=0, parity_err=0; status high for the whole frame.
- type=1: send 0x3C with parity bit 0, then 0x3C with parity bit 1 -> parity_err=0, then parity_err=1; both rx_data=0x3C.
- 4-cycle low glitch on idle rxd -> START rejects it, status returns to 0, no rx_valid.
- Send 0x55 with stop bit forced low, hold rxd low 40 cycles, then high, then send 0x0F -> frame_err=1 with 0x55; no start detected during the low hold; 0x0F received clean.
- Two back-to-back frames 0x01, 0xFE with no idle gap -> two strobes, correct data, spacing 10·16 cycles ±1.
- Assert rst_n=0 during bit 4 of a frame, release, send 0x81 -> no strobe for the aborted frame; 0x81 received. With UART_RX_HOLD_EN, send two frames without rx_ack -> overrun=1, rx_data=second byte.
